// File: rtl/_ser2par_en.sv
// Serial-in/parallel-out collector: gathers WIDTH strobed bits and presents the
// completed word on p_out with a one-cycle load_en for downstream enable-flops.
module _ser2par_en #(
   parameter int WIDTH     = 8,
   parameter int CNT_W     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             en,
   input  logic             s_in,
   input  logic             abort,
   output logic [WIDTH-1:0] p_out,
   output logic             load_en,
   output logic             busy,
   output logic [CNT_W-1:0] cnt
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sr, sr_nxt, p_out_nxt;
   logic [CNT_W-1:0] cnt_nxt;

   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] r, input logic b);
      if (MSB_FIRST)
         return {r[WIDTH-2:0], b};
      else
         return {b, r[WIDTH-1:1]};
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         sr    <= '0;
         cnt   <= '0;
         p_out <= '0;
      end else begin
         state <= state_nxt;
         sr    <= sr_nxt;
         cnt   <= cnt_nxt;
         p_out <= p_out_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sr_nxt    = sr;
      cnt_nxt   = cnt;
      p_out_nxt = p_out;
      load_en   = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            // start also wins over a simultaneous abort here
            if (start) begin
               state_nxt = SHIFT;
               sr_nxt    = '0;
               cnt_nxt   = '0;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (abort) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (en) begin
               sr_nxt  = shift_in(sr, s_in);
               cnt_nxt = cnt + CNT_ONE;
               if (cnt == CNT_LAST) begin
                  p_out_nxt = shift_in(sr, s_in);
                  cnt_nxt   = CNT_FULL;
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            load_en = 1'b1;
            cnt_nxt = '0;
            // a start here chains the next word without an idle cycle
            if (start) begin
               state_nxt = SHIFT;
               sr_nxt    = '0;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb__ser2par_en.sv
// Directed bench for _ser2par_en: one MSB-first and one LSB-first instance
// share the same stimulus so each word is checked in both bit orders.
module tb__ser2par_en;

   logic       clk, reset_n, start, en, s_in, abort;
   logic [7:0] p_out_m, p_out_l;
   logic       load_en_m, load_en_l, busy_m, busy_l;
   logic [3:0] cnt_m, cnt_l;

   int pass_cnt = 0;
   int fail_cnt = 0;
   int total    = 0;

   _ser2par_en #(.WIDTH(8), .CNT_W(4), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .reset_n(reset_n), .start(start), .en(en), .s_in(s_in), .abort(abort),
      .p_out(p_out_m), .load_en(load_en_m), .busy(busy_m), .cnt(cnt_m));

   _ser2par_en #(.WIDTH(8), .CNT_W(4), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .reset_n(reset_n), .start(start), .en(en), .s_in(s_in), .abort(abort),
      .p_out(p_out_l), .load_en(load_en_l), .busy(busy_l), .cnt(cnt_l));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Feeds bits w[7], w[6], ... ; after bit number gap_at, holds en low for 3 cycles.
   task automatic feed(input string tag, input logic [7:0] w, input int nbits, input int gap_at);
      for (int i = 0; i < nbits; i++) begin
         en   = 1'b1;
         s_in = w[7-i];
         tick();
         en = 1'b0;
         if (i < 7) begin
            chk({tag, "_cnt"}, {28'd0, cnt_m}, i + 1);
            chk({tag, "_noload"}, {31'd0, load_en_m}, 0);
         end
         if (i + 1 == gap_at) begin
            for (int g = 0; g < 3; g++) begin
               tick();
               chk({tag, "_gapcnt"}, {28'd0, cnt_m}, gap_at);
               chk({tag, "_gapbusy"}, {31'd0, busy_m}, 1);
            end
         end
      end
   endtask

   task automatic do_start;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic chk_done(input string tag, input logic [7:0] exp_m, input logic [7:0] exp_l);
      chk({tag, "_load_m"}, {31'd0, load_en_m}, 1);
      chk({tag, "_load_l"}, {31'd0, load_en_l}, 1);
      chk({tag, "_pout_m"}, {24'd0, p_out_m}, {24'd0, exp_m});
      chk({tag, "_pout_l"}, {24'd0, p_out_l}, {24'd0, exp_l});
      chk({tag, "_cnt8"}, {28'd0, cnt_l}, 8);
      chk({tag, "_busy"}, {31'd0, busy_m}, 0);
   endtask

   task automatic chk_after(input string tag, input logic [7:0] exp_m);
      chk({tag, "_load_off"}, {30'd0, load_en_m, load_en_l}, 0);
      chk({tag, "_cnt0"}, {24'd0, cnt_m, cnt_l}, 0);
      chk({tag, "_idle"}, {31'd0, busy_m}, 0);
      chk({tag, "_hold"}, {24'd0, p_out_m}, {24'd0, exp_m});
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; en = 1'b0; s_in = 1'b0; abort = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_pout", {16'd0, p_out_m, p_out_l}, 0);
      chk("rst_ctl", {28'd0, load_en_m, busy_m, load_en_l, busy_l}, 0);
      chk("rst_cnt", {24'd0, cnt_m, cnt_l}, 0);
      reset_n = 1'b1;
      tick();

      // Bits in IDLE are ignored
      en = 1'b1; s_in = 1'b1;
      tick();
      en = 1'b0;
      chk("idle_ignore", {27'd0, cnt_m, busy_m}, 0);

      // T2 / T6: plain word
      do_start();
      chk("t2_busy", {31'd0, busy_m}, 1);
      chk("t2_cnt0", {28'd0, cnt_m}, 0);
      feed("t2", 8'hB2, 8, 0);
      chk_done("t2", 8'hB2, 8'h4D);
      tick();
      chk_after("t2", 8'hB2);

      // T3: gap after the 4th bit
      do_start();
      feed("t3", 8'hB2, 8, 4);
      chk_done("t3", 8'hB2, 8'h4D);
      tick();
      chk_after("t3", 8'hB2);

      // T4: start+abort together in IDLE, then abort mid-word with en high
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("t4_start_wins", {31'd0, busy_m}, 1);
      feed("t4", 8'hFF, 5, 0);
      abort = 1'b1; en = 1'b1; s_in = 1'b1;
      tick();
      abort = 1'b0; en = 1'b0;
      chk("t4_abort_busy", {31'd0, busy_m}, 0);
      chk("t4_abort_cnt", {28'd0, cnt_m}, 0);
      chk("t4_abort_load", {31'd0, load_en_m}, 0);
      tick();
      chk_after("t4", 8'hB2);

      // T5: back-to-back, start during DONE
      do_start();
      feed("t5a", 8'hB2, 8, 0);
      chk_done("t5a", 8'hB2, 8'h4D);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t5_chain_busy", {31'd0, busy_m}, 1);
      chk("t5_chain_load", {31'd0, load_en_m}, 0);
      chk("t5_chain_cnt", {28'd0, cnt_m}, 0);
      feed("t5b", 8'h5A, 8, 0);
      chk_done("t5b", 8'h5A, 8'h5A);
      tick();
      chk_after("t5b", 8'h5A);

      // T1: asynchronous reset between clock edges in the middle of a word
      do_start();
      feed("t1", 8'hB2, 3, 0);
      #2 reset_n = 1'b0;
      #1;
      chk("t1_pout", {16'd0, p_out_m, p_out_l}, 0);
      chk("t1_ctl", {28'd0, load_en_m, busy_m, load_en_l, busy_l}, 0);
      chk("t1_cnt", {24'd0, cnt_m, cnt_l}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      en = 1'b1; s_in = 1'b1;
      tick();
      en = 1'b0;
      chk("t1_idle_after", {27'd0, cnt_m, busy_m}, 0);

      // Partial word discarded: a fresh word completes normally
      do_start();
      feed("t1w", 8'h5A, 8, 0);
      chk_done("t1w", 8'h5A, 8'h5A);
      tick();
      chk_after("t1w", 8'h5A);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
